// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: registers decoded fields, derives the ALU control code,
// forwards EX operands and flags hazards. Forwarding is present only when EX_FWD_EN is defined.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_alu_op,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          ex_valid,
    output logic [DW-1:0] op_1,
    output logic [DW-1:0] op_2,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wr_reg,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_illegal,
    output logic          hazard_stall
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic          r_valid;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [15:0]   r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_wr_reg;
    logic [3:0]    r_alu_ctrl;
    logic          r_alu_src;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_mem_to_reg;
    logic          r_illegal;

    logic [3:0]    w_alu_ctrl;
    logic          w_illegal;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;
    logic [DW-1:0] w_imm_ext;
    logic          w_load_use;
    logic          w_bubble;

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_illegal  = 1'b0;
        unique case (id_alu_op)
            2'b00: w_alu_ctrl = ALU_ADD;
            2'b01: w_alu_ctrl = ALU_SUB;
            2'b11: w_alu_ctrl = ALU_SLT;
            default: begin
                case (id_funct)
                    6'h20:   w_alu_ctrl = ALU_ADD;
                    6'h22:   w_alu_ctrl = ALU_SUB;
                    6'h24:   w_alu_ctrl = ALU_AND;
                    6'h25:   w_alu_ctrl = ALU_OR;
                    6'h2A:   w_alu_ctrl = ALU_SLT;
                    6'h27:   w_alu_ctrl = ALU_NOR;
                    default: w_illegal  = 1'b1;
                endcase
            end
        endcase
    end

    // A load without a real instruction is indistinguishable from a flush.
    assign w_bubble = flush || (!stall && !id_valid);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_wr_reg     <= '0;
            r_alu_ctrl   <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_wr_reg     <= id_reg_dst ? id_rd : id_rt;
            r_alu_ctrl   <= w_alu_ctrl;
            r_alu_src    <= id_alu_src;
            r_reg_write  <= id_reg_write && !w_illegal;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_illegal    <= w_illegal;
        end
    end

    assign w_load_use = id_valid && r_valid && r_mem_read && (r_wr_reg != '0) &&
                        ((r_wr_reg == id_rs) || (r_wr_reg == id_rt));

`ifdef EX_FWD_EN
    // EX/MEM is the younger result, so it takes priority over MEM/WB.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs))
            w_fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs))
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt))
            w_fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt))
            w_fwd_rt = memwb_result;
    end

    assign hazard_stall = w_load_use;
`else
    logic w_raw_ex;
    logic w_raw_exmem;
    logic w_unused;

    assign w_fwd_rs = r_rs_data;
    assign w_fwd_rt = r_rt_data;

    // Without forwarding, any pending write to a source register must drain first.
    assign w_raw_ex    = id_valid && r_valid && r_reg_write && (r_wr_reg != '0) &&
                         ((r_wr_reg == id_rs) || (r_wr_reg == id_rt));
    assign w_raw_exmem = id_valid && exmem_reg_write && (exmem_rd != '0) &&
                         ((exmem_rd == id_rs) || (exmem_rd == id_rt));

    assign hazard_stall = w_load_use || w_raw_ex || w_raw_exmem;
    assign w_unused     = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, r_rs, r_rt};
`endif

    assign w_imm_ext     = {{(DW-16){r_imm[15]}}, r_imm};
    assign op_1          = w_fwd_rs;
    assign op_2          = r_alu_src ? w_imm_ext : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_valid      = r_valid;
    assign alu_ctrl      = r_alu_ctrl;
    assign ex_wr_reg     = r_wr_reg;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then randomized traffic,
// checked against an instruction-level model of the EX stage.
module tb_id_ex_stage;

    typedef struct packed {
        bit        rst_n, stall, flush, id_valid;
        bit [31:0] rs_data, rt_data;
        bit [15:0] imm;
        bit [4:0]  rs, rt, rd;
        bit [5:0]  funct;
        bit [1:0]  alu_op;
        bit        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
        bit        exmem_reg_write;
        bit [4:0]  exmem_rd;
        bit [31:0] exmem_result;
        bit        memwb_reg_write;
        bit [4:0]  memwb_rd;
        bit [31:0] memwb_result;
    } stim_t;

    // Instruction currently held in EX, as the model understands it.
    typedef struct packed {
        bit        valid;
        bit [31:0] rs_val, rt_val, imm_ext;
        bit [4:0]  src_rs, src_rt, dest;
        bit [3:0]  op;
        bit        alu_src, wr, mrd, mwr, m2r, ill;
    } ex_t;

    typedef struct packed {
        bit        data_chk;
        bit        valid, wr, mrd, mwr, m2r, ill, haz;
        bit [31:0] op1, op2, sd;
        bit [3:0]  alu;
        bit [4:0]  wreg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
    logic        hazard_stall;
    logic [31:0] op_1, op_2, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_wr_reg;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .op_1(op_1), .op_2(op_2), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    int   n_total  = 0;
    int   n_passed = 0;
    exp_t exp_q[$];
    ex_t  m_ex;
    bit   model_known = 1'b0;
    bit   pristine    = 1'b0;
    bit [3:0] funct_tbl [bit [5:0]];
    bit [5:0] legal_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_passed++;
    endtask

    function automatic void alu_decode(input bit [1:0] alu_op, input bit [5:0] funct,
                                       output bit [3:0] op, output bit ill);
        ill = 1'b0;
        case (alu_op)
            2'd0: op = 4'b0010;
            2'd1: op = 4'b0110;
            2'd3: op = 4'b0111;
            default: begin
                if (funct_tbl.exists(funct)) op = funct_tbl[funct];
                else begin
                    op  = 4'b0010;
                    ill = 1'b1;
                end
            end
        endcase
    endfunction

    function automatic bit [31:0] fwd(input stim_t s, input bit [4:0] src, input bit [31:0] val);
        bit [31:0] r = val;
`ifdef EX_FWD_EN
        if (src != 0 && s.memwb_reg_write && s.memwb_rd == src) r = s.memwb_result;
        if (src != 0 && s.exmem_reg_write && s.exmem_rd == src) r = s.exmem_result;
`else
        if (s.exmem_reg_write && src == 5'd31) r = val;
`endif
        return r;
    endfunction

    function automatic bit hazard(input stim_t s, input ex_t ex);
        bit [4:0] srcs [2];
        bit h = 1'b0;
        srcs[0] = s.rs;
        srcs[1] = s.rt;
        if (!s.id_valid) return 1'b0;
        foreach (srcs[i]) begin
            if (srcs[i] != 0) begin
                if (ex.valid && ex.mrd && ex.dest == srcs[i]) h = 1'b1;
`ifndef EX_FWD_EN
                if (ex.valid && ex.wr && ex.dest == srcs[i]) h = 1'b1;
                if (s.exmem_reg_write && s.exmem_rd == srcs[i]) h = 1'b1;
`endif
            end
        end
        return h;
    endfunction

    // One clock: drive inputs, record what EX must show now, then advance the model past the edge.
    task automatic drive(input stim_t s);
        exp_t e;
        bit [31:0] rt_f;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
        id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_funct = s.funct; id_alu_op = s.alu_op;
        id_alu_src = s.alu_src; id_reg_dst = s.reg_dst; id_reg_write = s.reg_write;
        id_mem_read = s.mem_read; id_mem_write = s.mem_write; id_mem_to_reg = s.mem_to_reg;
        exmem_reg_write = s.exmem_reg_write; exmem_rd = s.exmem_rd; exmem_result = s.exmem_result;
        memwb_reg_write = s.memwb_reg_write; memwb_rd = s.memwb_rd; memwb_result = s.memwb_result;
        if (model_known) begin
            rt_f       = fwd(s, m_ex.src_rt, m_ex.rt_val);
            e.data_chk = m_ex.valid || pristine;
            e.valid    = m_ex.valid;
            e.wr       = m_ex.wr;
            e.mrd      = m_ex.mrd;
            e.mwr      = m_ex.mwr;
            e.m2r      = m_ex.m2r;
            e.ill      = m_ex.ill;
            e.haz      = hazard(s, m_ex);
            e.op1      = fwd(s, m_ex.src_rs, m_ex.rs_val);
            e.op2      = m_ex.alu_src ? m_ex.imm_ext : rt_f;
            e.sd       = rt_f;
            e.alu      = m_ex.op;
            e.wreg     = m_ex.dest;
            exp_q.push_back(e);
        end
        if (!s.rst_n) begin
            m_ex        = '0;
            model_known = 1'b1;
            pristine    = 1'b1;
        end else if (s.flush || (!s.stall && !s.id_valid)) begin
            m_ex.valid = 1'b0;
            m_ex.wr    = 1'b0;
            m_ex.mrd   = 1'b0;
            m_ex.mwr   = 1'b0;
            m_ex.ill   = 1'b0;
        end else if (!s.stall) begin
            m_ex.valid   = 1'b1;
            m_ex.rs_val  = s.rs_data;
            m_ex.rt_val  = s.rt_data;
            m_ex.imm_ext = 32'($signed(s.imm));
            m_ex.src_rs  = s.rs;
            m_ex.src_rt  = s.rt;
            m_ex.dest    = s.reg_dst ? s.rd : s.rt;
            alu_decode(s.alu_op, s.funct, m_ex.op, m_ex.ill);
            m_ex.alu_src = s.alu_src;
            m_ex.wr      = s.reg_write && !m_ex.ill;
            m_ex.mrd     = s.mem_read;
            m_ex.mwr     = s.mem_write;
            m_ex.m2r     = s.mem_to_reg;
            pristine     = 1'b0;
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n           = ($urandom_range(0, 49) != 0);
        s.stall           = ($urandom_range(0, 4) == 0);
        s.flush           = ($urandom_range(0, 6) == 0);
        s.id_valid        = ($urandom_range(0, 3) != 0);
        s.rs_data         = $urandom;
        s.rt_data         = $urandom;
        s.imm             = 16'($urandom);
        s.rs              = 5'($urandom_range(0, 7));
        s.rt              = 5'($urandom_range(0, 7));
        s.rd              = 5'($urandom_range(0, 7));
        s.funct           = ($urandom_range(0, 3) != 0) ? legal_funct[$urandom_range(0, 5)]
                                                        : 6'($urandom);
        s.alu_op          = 2'($urandom);
        s.alu_src         = 1'($urandom);
        s.reg_dst         = 1'($urandom);
        s.reg_write       = 1'($urandom);
        s.mem_read        = ($urandom_range(0, 2) == 0);
        s.mem_write       = 1'($urandom);
        s.mem_to_reg      = 1'($urandom);
        s.exmem_reg_write = 1'($urandom);
        s.exmem_rd        = 5'($urandom_range(0, 7));
        s.exmem_result    = $urandom;
        s.memwb_reg_write = 1'($urandom);
        s.memwb_rd        = 5'($urandom_range(0, 7));
        s.memwb_result    = $urandom;
        return s;
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ex_valid", 32'(ex_valid), 32'(e.valid));
                check("ex_reg_write", 32'(ex_reg_write), 32'(e.wr));
                check("ex_mem_read", 32'(ex_mem_read), 32'(e.mrd));
                check("ex_mem_write", 32'(ex_mem_write), 32'(e.mwr));
                check("ex_illegal", 32'(ex_illegal), 32'(e.ill));
                check("hazard_stall", 32'(hazard_stall), 32'(e.haz));
                if (e.data_chk) begin
                    check("op_1", op_1, e.op1);
                    check("op_2", op_2, e.op2);
                    check("ex_store_data", ex_store_data, e.sd);
                    check("alu_ctrl", 32'(alu_ctrl), 32'(e.alu));
                    check("ex_wr_reg", 32'(ex_wr_reg), 32'(e.wreg));
                    check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        funct_tbl[6'h20] = 4'b0010;
        funct_tbl[6'h22] = 4'b0110;
        funct_tbl[6'h24] = 4'b0000;
        funct_tbl[6'h25] = 4'b0001;
        funct_tbl[6'h2A] = 4'b0111;
        funct_tbl[6'h27] = 4'b1100;

        // Reset for two cycles, then idle.
        s = idle(); s.rst_n = 1'b0;
        drive(s);
        drive(s);
        drive(idle());
        drive(idle());

        // R-type add: 5 + 7.
        s = idle(); s.id_valid = 1; s.rs = 1; s.rt = 2; s.rd = 5; s.rs_data = 5; s.rt_data = 7;
        s.funct = 6'h20; s.alu_op = 2'b10; s.reg_dst = 1; s.reg_write = 1;
        drive(s);

        // Forwarding onto rs=3, held by stall across the variants.
        s = idle(); s.id_valid = 1; s.rs = 3; s.rt = 6; s.rs_data = 32'h11; s.rt_data = 32'h22;
        s.alu_op = 2'b00; s.reg_write = 1; s.rd = 7;
        drive(s);
        s = idle(); s.stall = 1; s.exmem_reg_write = 1; s.exmem_rd = 3; s.exmem_result = 32'hAA;
        s.memwb_reg_write = 1; s.memwb_rd = 3; s.memwb_result = 32'hBB;
        drive(s);
        s.exmem_rd = 0;
        drive(s);
        s.memwb_rd = 0;
        drive(s);

        // Load-use: lw $4, then a consumer of $4 with the controller's flush.
        s = idle(); s.id_valid = 1; s.rs = 1; s.rt = 4; s.alu_src = 1; s.imm = 16'h0010;
        s.reg_write = 1; s.mem_read = 1; s.mem_to_reg = 1;
        drive(s);
        s = idle(); s.id_valid = 1; s.rs = 2; s.rt = 4; s.flush = 1;
        drive(s);
        drive(idle());

        // addi with negative immediate, held three cycles, then stall+flush.
        s = idle(); s.id_valid = 1; s.rs = 2; s.rt = 6; s.rs_data = 32'h100; s.imm = 16'hFFFE;
        s.alu_src = 1; s.reg_write = 1;
        drive(s);
        s = idle(); s.stall = 1;
        drive(s);
        drive(s);
        drive(s);
        s.flush = 1;
        drive(s);
        drive(idle());

        // Unsupported funct under ALUOp 10.
        s = idle(); s.id_valid = 1; s.funct = 6'h3F; s.alu_op = 2'b10; s.reg_dst = 1;
        s.rd = 9; s.reg_write = 1; s.rs = 1; s.rt = 2;
        drive(s);
        drive(idle());

        for (int i = 0; i < 600; i++) drive(rand_stim());
        drive(idle());

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
